// File: rtl/ac_job_controller.sv
// Job controller for arithmetic_coder: takes in one symbol stream, triggers the encode,
// then reads back and parses the coder's frame and forwards it as a back-pressured byte stream.
module ac_job_controller #(
   parameter int MAX_SYMBOLS    = 128,
   parameter int SETTLE_CYCLES  = 50,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   output logic [7:0]  ac_symbol_in,
   output logic        ac_valid_in,
   output logic        ac_wr_complete_in,
   output logic        ac_next_in,
   input  logic [7:0]  ac_data_out,
   input  logic        ac_valid_out,
   output logic [7:0]  m_data,
   output logic        m_valid,
   output logic        m_last,
   input  logic        m_ready,
   output logic        busy,
   output logic        done,
   output logic        err_timeout,
   output logic        err_trunc,
   output logic [7:0]  sym_count,
   output logic [15:0] comp_len
);

   typedef enum logic [3:0] {
      IDLE, FEED, DISCARD, SETTLE, FLUSH, HDR, TABLE, LEN_HI, LEN_LO, PAYLOAD, ABORT
   } state_t;

   localparam int SW = $clog2(SETTLE_CYCLES + 2);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   state_t          state, state_nxt;
   logic [SW-1:0]   settle_cnt;
   logic [TW-1:0]   tmo_cnt;
   logic [9:0]      tbl_cnt;
   logic [9:0]      tbl_len;
   logic [7:0]      len_hi;
   logic [15:0]     pay_cnt;
   logic [15:0]     lo_len;
   logic [16:0]     req_cnt;
   logic [16:0]     limit;
   logic [16:0]     eff_limit;
   logic            req_d;
   logic [1:0][7:0] buf_data;
   logic [1:0]      buf_last;
   logic            wr_ptr, rd_ptr;
   logic [1:0]      buf_cnt;
   logic [7:0]      sym_next;
   logic            readout, pop, cap_last;

   assign s_ready           = (state == IDLE) || (state == FEED) || (state == DISCARD);
   assign busy              = (state != IDLE);
   assign readout           = (state == HDR) || (state == TABLE) || (state == LEN_HI) ||
                              (state == LEN_LO) || (state == PAYLOAD);
   assign ac_wr_complete_in = (state == FLUSH) || readout;
   assign sym_next          = (state == IDLE) ? 8'd1 : sym_count + 8'd1;
   assign tbl_len           = 10'd3 * ({2'b00, ac_data_out} + 10'd1);
   assign lo_len            = {len_hi, ac_data_out};

   // Until byte0 arrives only the 6-byte minimum frame is safe to request; the low length
   // byte is used straight off the coder bus so the request stream ends exactly on time.
   assign eff_limit = (req_d && state == LEN_LO) ? limit + {1'b0, lo_len} : limit;
   assign cap_last  = (state == LEN_LO && lo_len == 16'd0) ||
                      (state == PAYLOAD && pay_cnt == 16'd1);

   assign m_valid    = (buf_cnt != 2'd0);
   assign m_data     = buf_data[rd_ptr];
   assign m_last     = m_valid && buf_last[rd_ptr];
   assign pop        = m_valid && m_ready;
   assign done       = (state == PAYLOAD) && pop && m_last;
   assign ac_next_in = readout && (req_cnt < eff_limit) &&
                       (({1'b0, buf_cnt} + {2'b00, req_d}) < (3'd2 + {2'b00, pop}));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; parse states advance once per captured coder byte.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, FEED: begin
            if (s_valid) begin
               if (s_last) begin
                  state_nxt = SETTLE;
               end else if (sym_next == 8'(MAX_SYMBOLS)) begin
                  state_nxt = DISCARD;
               end else begin
                  state_nxt = FEED;
               end
            end
         end
         DISCARD: if (s_valid && s_last) state_nxt = SETTLE;
         SETTLE:  if (settle_cnt == SW'(SETTLE_CYCLES)) state_nxt = FLUSH;
         FLUSH: begin
            if (ac_valid_out) begin
               state_nxt = HDR;
            end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               state_nxt = ABORT;
            end
         end
         HDR:     if (req_d) state_nxt = TABLE;
         TABLE:   if (req_d && tbl_cnt == 10'd1) state_nxt = LEN_HI;
         LEN_HI:  if (req_d) state_nxt = LEN_LO;
         LEN_LO:  if (req_d) state_nxt = PAYLOAD;
         PAYLOAD: if (done) state_nxt = IDLE;
         ABORT:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Symbol intake, job counters, header parsing and the 2-entry output buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ac_symbol_in <= 8'd0;
         ac_valid_in  <= 1'b0;
         sym_count    <= 8'd0;
         err_trunc    <= 1'b0;
         err_timeout  <= 1'b0;
         comp_len     <= 16'd0;
         settle_cnt   <= '0;
         tmo_cnt      <= '0;
         tbl_cnt      <= 10'd0;
         len_hi       <= 8'd0;
         pay_cnt      <= 16'd0;
         req_cnt      <= 17'd0;
         limit        <= 17'd0;
         req_d        <= 1'b0;
         buf_data     <= '0;
         buf_last     <= 2'b00;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         buf_cnt      <= 2'd0;
      end else begin
         ac_valid_in <= 1'b0;
         if ((state == IDLE || state == FEED) && s_valid) begin
            ac_symbol_in <= s_data;
            ac_valid_in  <= 1'b1;
            sym_count    <= sym_next;
            if (state == IDLE) begin
               err_timeout <= 1'b0;
               err_trunc   <= 1'b0;
            end
            if (!s_last && sym_next == 8'(MAX_SYMBOLS)) begin
               err_trunc <= 1'b1;
            end
         end

         settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
         tmo_cnt    <= (state == FLUSH) ? tmo_cnt + 1'b1 : '0;
         if (state == FLUSH && !ac_valid_out && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            err_timeout <= 1'b1;
         end

         req_d <= ac_next_in;
         if (state == FLUSH) begin
            req_cnt <= 17'd0;
            limit   <= 17'd6;
         end else if (ac_next_in) begin
            req_cnt <= req_cnt + 17'd1;
         end

         if (req_d) begin
            case (state)
               HDR: begin
                  tbl_cnt <= tbl_len;
                  limit   <= {7'd0, tbl_len} + 17'd3;
               end
               TABLE:  tbl_cnt <= tbl_cnt - 10'd1;
               LEN_HI: len_hi <= ac_data_out;
               LEN_LO: begin
                  comp_len <= lo_len;
                  pay_cnt  <= lo_len;
                  limit    <= eff_limit;
               end
               PAYLOAD: pay_cnt <= pay_cnt - 16'd1;
               default: ;
            endcase
            buf_data[wr_ptr] <= ac_data_out;
            buf_last[wr_ptr] <= cap_last;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         buf_cnt <= buf_cnt + {1'b0, req_d} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_ac_job_controller.sv
// Self-checking bench for ac_job_controller: a behavioural coder stub serves constructed
// frames, and scoreboards track both the symbols fed to the coder and the bytes forwarded.
module tb_ac_job_controller;

   localparam int MAX_SYMBOLS    = 128;
   localparam int SETTLE_CYCLES  = 50;
   localparam int TIMEOUT_CYCLES = 4096;
   localparam int STUB_DELAY     = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  s_data;
   logic        s_valid, s_last, s_ready;
   logic [7:0]  ac_symbol_in;
   logic        ac_valid_in, ac_wr_complete_in, ac_next_in;
   logic [7:0]  ac_data_out;
   logic        ac_valid_out;
   logic [7:0]  m_data;
   logic        m_valid, m_last, m_ready;
   logic        busy, done, err_timeout, err_trunc;
   logic [7:0]  sym_count;
   logic [15:0] comp_len;

   int n_compared = 0;
   int n_mismatched = 0;
   int cyc = 0;

   logic [7:0] sym_q[$];
   logic [8:0] exp_q[$];
   logic [7:0] frame_q[$];

   bit   ready_mode;
   bit   stub_respond;
   logic [15:0] lfsr = 16'hACE1;
   int   stub_idx, stub_wait;

   int   vin_total, out_total, done_total, nin_total;
   int   wrc_rise_cyc, errt_rise_cyc, busy_fall_cyc, vo_cyc, nin_cyc, mv_cyc, hs_cyc;

   ac_job_controller #(
      .MAX_SYMBOLS(MAX_SYMBOLS), .SETTLE_CYCLES(SETTLE_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .rst(rst),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .ac_symbol_in(ac_symbol_in), .ac_valid_in(ac_valid_in),
      .ac_wr_complete_in(ac_wr_complete_in), .ac_next_in(ac_next_in),
      .ac_data_out(ac_data_out), .ac_valid_out(ac_valid_out),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .busy(busy), .done(done), .err_timeout(err_timeout), .err_trunc(err_trunc),
      .sym_count(sym_count), .comp_len(comp_len)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Coder stub: raises valid_out a few cycles after wr_complete, then serves frame_q per next_in.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ac_valid_out <= 1'b0;
         ac_data_out  <= 8'd0;
         stub_idx     <= 0;
         stub_wait    <= 0;
      end else if (!ac_wr_complete_in) begin
         ac_valid_out <= 1'b0;
         stub_idx     <= 0;
         stub_wait    <= 0;
      end else begin
         if (stub_respond) begin
            if (stub_wait < STUB_DELAY) stub_wait <= stub_wait + 1;
            else ac_valid_out <= 1'b1;
         end
         if (ac_next_in) begin
            ac_data_out <= (stub_idx < frame_q.size()) ? frame_q[stub_idx] : 8'hEE;
            stub_idx    <= stub_idx + 1;
         end
      end
   end

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic driveReady();
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode) begin
            lfsr    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            m_ready = lfsr[0];
         end else begin
            m_ready = 1'b1;
         end
      end
   endtask

   // Samples on the falling edge: pops scoreboards and records event cycles.
   task automatic monitor();
      logic [7:0] es;
      logic [8:0] eb;
      logic prev_wrc = 1'b0, prev_busy = 1'b0, prev_errt = 1'b0;
      bit seen_vo = 0, seen_nin = 0, seen_mv = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (ac_valid_in) begin
               vin_total++;
               if (sym_q.size() > 0) begin
                  es = sym_q.pop_front();
                  checkOutput("symbol", 32'(ac_symbol_in), 32'(es));
               end else begin
                  checkOutput("symbol_extra", 32'(ac_valid_in), 32'd0);
               end
            end
            if (m_valid && m_ready) begin
               out_total++;
               if (exp_q.size() > 0) begin
                  eb = exp_q.pop_front();
                  checkOutput("m_data", 32'(m_data), 32'(eb[7:0]));
                  checkOutput("m_last", 32'(m_last), 32'(eb[8]));
                  checkOutput("done_on_last", 32'(done), 32'(eb[8]));
               end else begin
                  checkOutput("m_extra", 32'(m_valid), 32'd0);
               end
            end else if (m_valid && exp_q.size() > 0) begin
               checkOutput("stall_data", 32'(m_data), 32'(exp_q[0][7:0]));
            end
            if (done) done_total++;
            if (ac_next_in) nin_total++;
            if (!ac_wr_complete_in) begin
               seen_vo = 0; seen_nin = 0; seen_mv = 0;
            end else begin
               if (ac_valid_out && !seen_vo) begin seen_vo = 1; vo_cyc = cyc; end
               if (ac_next_in && !seen_nin) begin seen_nin = 1; nin_cyc = cyc; end
               if (m_valid && !seen_mv) begin seen_mv = 1; mv_cyc = cyc; end
            end
            if (ac_wr_complete_in && !prev_wrc) wrc_rise_cyc = cyc;
            if (err_timeout && !prev_errt) errt_rise_cyc = cyc;
            if (!busy && prev_busy) busy_fall_cyc = cyc;
         end
         prev_wrc  = ac_wr_complete_in;
         prev_busy = busy;
         prev_errt = err_timeout;
      end
   endtask

   task automatic checkResetOutputs();
      checkOutput("rst_s_ready", 32'(s_ready), 32'd1);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
      checkOutput("rst_m_data", 32'(m_data), 32'd0);
      checkOutput("rst_m_last", 32'(m_last), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_ac_valid_in", 32'(ac_valid_in), 32'd0);
      checkOutput("rst_ac_symbol_in", 32'(ac_symbol_in), 32'd0);
      checkOutput("rst_wr_complete", 32'(ac_wr_complete_in), 32'd0);
      checkOutput("rst_next_in", 32'(ac_next_in), 32'd0);
      checkOutput("rst_err_timeout", 32'(err_timeout), 32'd0);
      checkOutput("rst_err_trunc", 32'(err_trunc), 32'd0);
      checkOutput("rst_sym_count", 32'(sym_count), 32'd0);
      checkOutput("rst_comp_len", 32'(comp_len), 32'd0);
   endtask

   // Builds the coder frame (byte0=N-1, 3N table bytes, length hi/lo, L payload bytes),
   // loads both scoreboards, feeds the symbols and optionally checks the finished job.
   task automatic applyStimulus(input int nsym, input int ntab, input int plen,
                                input bit respond, input bit lfsr_ready, input bit wait_end);
      int fed, flen, guard;
      int vin0, out0, done0, nin0;
      logic [7:0] b;
      fed  = (nsym < MAX_SYMBOLS) ? nsym : MAX_SYMBOLS;
      flen = 1 + 3 * ntab + 2 + plen;
      frame_q.delete();
      for (int i = 0; i < flen; i++) begin
         if (i == 0) b = 8'(ntab - 1);
         else if (i <= 3 * ntab) b = 8'(i * 13 + 7);
         else if (i == 3 * ntab + 1) b = 8'(plen >> 8);
         else if (i == 3 * ntab + 2) b = 8'(plen);
         else b = 8'(i * 29 + 101);
         frame_q.push_back(b);
         if (respond) exp_q.push_back({(i == flen - 1), b});
      end
      stub_respond = respond;
      ready_mode   = lfsr_ready;
      vin0 = vin_total; out0 = out_total; done0 = done_total; nin0 = nin_total;

      @(posedge clk);
      #1;
      for (int i = 0; i < nsym; i++) begin
         s_data  = 8'(i * 37 + nsym);
         s_valid = 1'b1;
         s_last  = (i == nsym - 1);
         if (i < MAX_SYMBOLS) sym_q.push_back(s_data);
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      hs_cyc  = cyc;
      @(negedge clk);
      checkOutput("s_ready_settle", 32'(s_ready), 32'd0);
      if (!wait_end) return;

      guard = 0;
      while (busy && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("job_end", 32'(busy), 32'd0);
      @(negedge clk);

      checkOutput("valid_in_pulses", 32'(vin_total - vin0), 32'(fed));
      checkOutput("sym_q_empty", 32'(sym_q.size()), 32'd0);
      checkOutput("sym_count", 32'(sym_count), 32'(fed));
      checkOutput("err_trunc", 32'(err_trunc), 32'(nsym > MAX_SYMBOLS));
      checkOutput("wr_complete_delay", 32'(wrc_rise_cyc - hs_cyc), 32'(SETTLE_CYCLES + 1));
      if (respond) begin
         checkOutput("err_timeout", 32'(err_timeout), 32'd0);
         checkOutput("frame_bytes", 32'(out_total - out0), 32'(flen));
         checkOutput("next_in_pulses", 32'(nin_total - nin0), 32'(flen));
         checkOutput("done_pulses", 32'(done_total - done0), 32'd1);
         checkOutput("exp_q_empty", 32'(exp_q.size()), 32'd0);
         checkOutput("comp_len", 32'(comp_len), 32'(plen));
         checkOutput("first_next_lat", 32'(nin_cyc - vo_cyc), 32'd1);
         checkOutput("first_mvalid_lat", 32'(mv_cyc - nin_cyc), 32'd2);
      end else begin
         checkOutput("err_timeout", 32'(err_timeout), 32'd1);
         checkOutput("timeout_delay", 32'(errt_rise_cyc - wrc_rise_cyc), 32'(TIMEOUT_CYCLES));
         checkOutput("abort_to_idle", 32'(busy_fall_cyc - errt_rise_cyc), 32'd1);
         checkOutput("abort_bytes", 32'(out_total - out0), 32'd0);
         checkOutput("abort_next_in", 32'(nin_total - nin0), 32'd0);
         checkOutput("abort_done", 32'(done_total - done0), 32'd0);
      end
   endtask

   initial begin
      int base, guard;
      rst = 1'b1; s_data = 8'd0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
      ready_mode = 0; stub_respond = 1;
      vin_total = 0; out_total = 0; done_total = 0; nin_total = 0;
      wrc_rise_cyc = 0; errt_rise_cyc = 0; busy_fall_cyc = 0;
      vo_cyc = 0; nin_cyc = 0; mv_cyc = 0; hs_cyc = 0;
      fork
         monitor();
         driveReady();
      join_none
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs();
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(98, 4, 20, 1, 0, 1);
      applyStimulus(98, 4, 20, 1, 1, 1);
      applyStimulus(130, 2, 10, 1, 0, 1);
      applyStimulus(5, 1, 4, 0, 0, 1);
      applyStimulus(3, 1, 0, 1, 0, 1);
      applyStimulus(20, 256, 300, 1, 1, 1);

      applyStimulus(40, 3, 60, 1, 0, 0);
      base  = out_total;
      guard = 0;
      while (out_total < base + 15 && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("reach_payload", 32'(out_total >= base + 15), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkResetOutputs();
      exp_q.delete();
      sym_q.delete();
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1, 1, 2, 1, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
